// File: rtl/rst_gen.sv
// rst_gen: reset source for the Segway controller.
// Merges the board reset (RST_n), a debounced pushbutton, a software request
// and an optional watchdog into one stretched, registered active-low reset.
// Reports the source of the last reset on rst_cause.
// Optional feature macro: RST_GEN_WDOG_EN builds the watchdog (cause 11).
module rst_gen #(
  parameter int DEB_BITS    = 16,
  parameter int HOLD_CYCLES = 1024,
  parameter int WDOG_BITS   = 24
) (
  input  logic       clk,
  input  logic       RST_n,
  input  logic       btn_n,
  input  logic       sw_rst_req,
  input  logic       wdog_kick,
  output logic       sys_rst_n,
  output logic       rst_busy,
  output logic [1:0] rst_cause
);

  localparam int HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    WAIT_REL = 2'd1,
    RUN      = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'b00,
    CAUSE_BTN  = 2'b01,
    CAUSE_SW   = 2'b10,
    CAUSE_WDOG = 2'b11
  } cause_t;

  state_t               state, next_state;
  cause_t               cause, next_cause;
  logic [HOLD_W-1:0]    hold_cnt;
  logic                 btn_meta, btn_s;
  logic [DEB_BITS-1:0]  deb_cnt;
  logic                 btn_evt;
  logic                 wdog_evt;

  // Two-flop synchronizer for the asynchronous pushbutton; idles released.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      btn_meta <= 1'b1;
      btn_s    <= 1'b1;
    end else begin
      // NOTE: every sequential block uses <= so all flops sample the same
      // pre-edge values; a blocking = here would collapse the two stages.
      btn_meta <= btn_n;
      btn_s    <= btn_meta;
    end
  end

  // Debounce: count stable-low cycles, saturating at all-ones.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      deb_cnt <= '0;
    end else if (btn_s) begin
      deb_cnt <= '0;
    end else if (!(&deb_cnt)) begin
      deb_cnt <= deb_cnt + DEB_BITS'(1);
    end
  end

  assign btn_evt = (&deb_cnt) & ~btn_s;

`ifdef RST_GEN_WDOG_EN
  logic [WDOG_BITS-1:0] wdog_cnt;

  // Watchdog: runs only in RUN; any kick or non-RUN state restarts it.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      wdog_cnt <= '0;
    end else if (wdog_kick || (state != RUN)) begin
      wdog_cnt <= '0;
    end else begin
      wdog_cnt <= wdog_cnt + WDOG_BITS'(1);
    end
  end

  assign wdog_evt = &wdog_cnt;
`else
  // Without the watchdog the kick input is accepted but has no effect.
  logic [WDOG_BITS-1:0] unused_wdog;
  assign unused_wdog = {WDOG_BITS{wdog_kick}};
  assign wdog_evt    = 1'b0;
`endif

  // Next-state and cause selection; button beats watchdog beats software.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    next_state = state;
    next_cause = cause;
    unique case (state)
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          next_state = btn_s ? RUN : WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (btn_s) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (btn_evt) begin
          next_state = HOLD;
          next_cause = CAUSE_BTN;
        end else if (wdog_evt) begin
          next_state = HOLD;
          next_cause = CAUSE_WDOG;
        end else if (sw_rst_req) begin
          next_state = HOLD;
          next_cause = CAUSE_SW;
        end
      end
      default: begin
        next_state = HOLD;
      end
    endcase
  end

  // State, hold counter and registered outputs; RST_n forces HOLD at once.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state     <= HOLD;
      cause     <= CAUSE_POR;
      hold_cnt  <= '0;
      sys_rst_n <= 1'b0;
      rst_busy  <= 1'b1;
    end else begin
      state     <= next_state;
      cause     <= next_cause;
      // Counting only while staying in HOLD means every entry starts at 0.
      hold_cnt  <= ((state == HOLD) && (next_state == HOLD))
                   ? hold_cnt + HOLD_W'(1) : '0;
      // Output flops are loaded from the next state so they change on the
      // same edge as the state register and never pass through logic.
      sys_rst_n <= (next_state == RUN);
      rst_busy  <= (next_state != RUN);
    end
  end

  assign rst_cause = cause;

endmodule

// File: tb/tb_rst_gen.sv
// tb_rst_gen: directed self-checking bench for rst_gen with DEB_BITS=4,
// HOLD_CYCLES=8, WDOG_BITS=6. Watchdog scenarios follow RST_GEN_WDOG_EN.
module tb_rst_gen;

  logic       clk = 1'b0;
  logic       RST_n;
  logic       btn_n;
  logic       sw_rst_req;
  logic       wdog_kick;
  logic       sys_rst_n;
  logic       rst_busy;
  logic [1:0] rst_cause;

  int checks = 0;
  int errors = 0;
  logic kick_en;
  logic all_high;
  logic no_wdog_cause;

  rst_gen #(
    .DEB_BITS   (4),
    .HOLD_CYCLES(8),
    .WDOG_BITS  (6)
  ) dut (
    .clk       (clk),
    .RST_n     (RST_n),
    .btn_n     (btn_n),
    .sw_rst_req(sw_rst_req),
    .wdog_kick (wdog_kick),
    .sys_rst_n (sys_rst_n),
    .rst_busy  (rst_busy),
    .rst_cause (rst_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present inputs before the edge, then settle 1 time unit past it.
  task automatic tick();
    wdog_kick = kick_en;
    @(posedge clk);
    #1;
  endtask

  // Expect exactly 8 low cycles: low after edges 1..7, high after edge 8.
  task automatic expect_pulse(input string tag);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check(tag, {31'd0, sys_rst_n}, (i == 8) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    RST_n      = 1'b0;
    btn_n      = 1'b1;
    sw_rst_req = 1'b0;
    kick_en    = 1'b1;
    wdog_kick  = 1'b1;

    // Power-on: reset values, then an 8-edge pulse after release.
    repeat (3) tick();
    check("por_sys", {31'd0, sys_rst_n}, 32'd0);
    check("por_busy", {31'd0, rst_busy}, 32'd1);
    check("por_cause", {30'd0, rst_cause}, 32'd0);
    RST_n = 1'b1;
    expect_pulse("por_pulse");
    check("por_run_busy", {31'd0, rst_busy}, 32'd0);
    check("por_run_cause", {30'd0, rst_cause}, 32'd0);
    repeat (3) tick();

    // Software request: 8-cycle pulse, second request inside HOLD ignored.
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("sw_fall", {31'd0, sys_rst_n}, 32'd0);
    check("sw_busy", {31'd0, rst_busy}, 32'd1);
    check("sw_cause", {30'd0, rst_cause}, 32'd2);
    for (int i = 1; i <= 8; i++) begin
      sw_rst_req = (i == 3);
      tick();
      check("sw_pulse", {31'd0, sys_rst_n}, (i == 8) ? 32'd1 : 32'd0);
    end
    sw_rst_req = 1'b0;
    tick();
    check("sw_cause_hold", {30'd0, rst_cause}, 32'd2);
    check("sw_no_ext", {31'd0, sys_rst_n}, 32'd1);

    // Button glitch of 5 cycles: debounce never saturates.
    btn_n    = 1'b0;
    all_high = 1'b1;
    repeat (5) begin tick(); all_high &= sys_rst_n; end
    btn_n = 1'b1;
    repeat (25) begin tick(); all_high &= sys_rst_n; end
    check("btn_glitch", {31'd0, all_high}, 32'd1);

    // Button held 40 cycles: reset on edge 18, WAIT_REL until release.
    btn_n = 1'b0;
    repeat (17) tick();
    check("btn_pre", {31'd0, sys_rst_n}, 32'd1);
    tick();
    check("btn_fall", {31'd0, sys_rst_n}, 32'd0);
    check("btn_cause", {30'd0, rst_cause}, 32'd1);
    repeat (22) tick();
    check("btn_wait_sys", {31'd0, sys_rst_n}, 32'd0);
    check("btn_wait_busy", {31'd0, rst_busy}, 32'd1);
    btn_n = 1'b1;
    repeat (2) tick();
    check("btn_rel_early", {31'd0, sys_rst_n}, 32'd0);
    tick();
    check("btn_rel_rise", {31'd0, sys_rst_n}, 32'd1);
    check("btn_rel_cause", {30'd0, rst_cause}, 32'd1);
    repeat (3) tick();

`ifdef RST_GEN_WDOG_EN
    // Watchdog kicked every 50 cycles: no reset.
    all_high = 1'b1;
    for (int i = 0; i < 150; i++) begin
      kick_en = (i % 50 == 0);
      tick();
      all_high &= sys_rst_n;
    end
    check("wdog_kicked", {31'd0, all_high}, 32'd1);

    // Unkicked: counter reaches all-ones after 63 edges, fires on the 64th.
    kick_en = 1'b1;
    tick();
    kick_en = 1'b0;
    repeat (63) tick();
    check("wdog_pre", {31'd0, sys_rst_n}, 32'd1);
    tick();
    check("wdog_fall", {31'd0, sys_rst_n}, 32'd0);
    check("wdog_cause", {30'd0, rst_cause}, 32'd3);
    kick_en = 1'b1;
    repeat (10) tick();
    check("wdog_recover", {31'd0, sys_rst_n}, 32'd1);

    // Priority: button, watchdog and software all on the same edge.
    tick();
    kick_en = 1'b0;
    repeat (46) tick();
    btn_n = 1'b0;
    repeat (17) tick();
    check("prio3_pre", {31'd0, sys_rst_n}, 32'd1);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("prio3_fall", {31'd0, sys_rst_n}, 32'd0);
    check("prio3_cause", {30'd0, rst_cause}, 32'd1);
    btn_n = 1'b1;
    repeat (12) tick();
    check("prio3_recover", {31'd0, sys_rst_n}, 32'd1);

    // Priority: watchdog and software together.
    kick_en = 1'b1;
    tick();
    kick_en = 1'b0;
    repeat (63) tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("prio2_cause", {30'd0, rst_cause}, 32'd3);
    kick_en = 1'b1;
    repeat (10) tick();
    check("prio2_recover", {31'd0, sys_rst_n}, 32'd1);
`else
    // Without the watchdog: 200 unkicked cycles cause nothing.
    kick_en       = 1'b0;
    all_high      = 1'b1;
    no_wdog_cause = 1'b1;
    repeat (200) begin
      tick();
      all_high      &= sys_rst_n;
      no_wdog_cause &= (rst_cause != 2'b11);
    end
    check("nowdog_no_rst", {31'd0, all_high}, 32'd1);
    check("nowdog_cause", {31'd0, no_wdog_cause}, 32'd1);
    kick_en = 1'b1;

    // Priority: button and software on the same edge.
    btn_n = 1'b0;
    repeat (17) tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("prio_fall", {31'd0, sys_rst_n}, 32'd0);
    check("prio_cause", {30'd0, rst_cause}, 32'd1);
    btn_n = 1'b1;
    repeat (12) tick();
    check("prio_recover", {31'd0, sys_rst_n}, 32'd1);
`endif

    // RST_n mid-pulse: cause clears at once, pulse restarts from zero.
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("mid_sw_cause", {30'd0, rst_cause}, 32'd2);
    repeat (4) tick();
    RST_n = 1'b0;
    #2;
    check("mid_async_cause", {30'd0, rst_cause}, 32'd0);
    check("mid_async_sys", {31'd0, sys_rst_n}, 32'd0);
    check("mid_async_busy", {31'd0, rst_busy}, 32'd1);
    repeat (2) tick();
    RST_n = 1'b1;
    expect_pulse("mid_pulse");
    check("mid_final_cause", {30'd0, rst_cause}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
